// File: rtl/pulse_averager.sv
// Coherent pulse averager: sums windowed ADC samples over n_avg periods into a RAM.
// Optional macro PULSE_AVERAGER_SHIFT_EN adds avg_shift (arithmetic right shift on readout).
module pulse_averager #(
    parameter int DATA_WIDTH  = 14,
    parameter int ADDR_WIDTH  = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int N_AVG_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic [N_AVG_WIDTH-1:0]       n_avg,
    input  logic                         start,
    input  logic                         valid,
    input  logic [ADDR_WIDTH-1:0]        cnt,
    input  logic signed [DATA_WIDTH-1:0] din,
`ifdef PULSE_AVERAGER_SHIFT_EN
    input  logic [4:0]                   avg_shift,
`endif
    output logic                         busy,
    output logic                         done,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [ACC_WIDTH-1:0]         rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACQ,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [N_AVG_WIDTH-1:0] K_ONE = N_AVG_WIDTH'(1);

    state_t                         r_state;
    logic [N_AVG_WIDTH-1:0]         r_k;
    logic [N_AVG_WIDTH-1:0]         r_navg;
    logic                           r_flush;
    logic                           r_busy;
    logic                           r_done;

    logic                           r_s0_vld;
    logic [ADDR_WIDTH-1:0]          r_s0_addr;
    logic signed [DATA_WIDTH-1:0]   r_s0_din;
    logic                           r_s0_first;
    logic                           r_s1_vld;
    logic [ADDR_WIDTH-1:0]          r_s1_addr;
    logic signed [DATA_WIDTH-1:0]   r_s1_din;
    logic                           r_s1_first;
    logic signed [ACC_WIDTH-1:0]    r_rdq;
    logic signed [ACC_WIDTH-1:0]    r_mem [DEPTH];

    logic                           w_end;
    logic                           w_accept;
    logic                           w_first;
    logic                           w_fwd;
    logic [ADDR_WIDTH-1:0]          w_raddr;
    logic signed [ACC_WIDTH-1:0]    w_sext;
    logic signed [ACC_WIDTH-1:0]    w_sum;

    always_comb begin
        w_end    = (r_state == S_ACQ) && start && (r_k == r_navg);
        w_accept = ((r_state == S_WAIT) && start) ||
                   ((r_state == S_ACQ) && !w_end);
        w_first  = (r_state == S_WAIT) || ((r_k == K_ONE) && !start);
        w_sext   = {{(ACC_WIDTH-DATA_WIDTH){r_s1_din[DATA_WIDTH-1]}},
                    r_s1_din};
        w_sum    = (r_s1_first ? '0 : r_rdq) + w_sext;
        // Back-to-back hits on one index: the RAM still holds the old value
        w_fwd    = r_busy && r_s0_vld && r_s1_vld &&
                   (r_s0_addr == r_s1_addr);
        w_raddr  = r_busy ? r_s0_addr : rd_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_navg  <= K_ONE;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        r_navg  <= (n_avg == '0) ? K_ONE : n_avg;
                        r_state <= S_WAIT;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (start) begin
                        r_k     <= K_ONE;
                        r_state <= S_ACQ;
                    end
                end
                S_ACQ: begin
                    if (w_end) begin
                        r_state <= S_FLUSH;
                        r_flush <= 1'b0;
                    end else if (start) begin
                        r_k <= r_k + K_ONE;
                    end
                end
                S_FLUSH: begin
                    if (r_flush) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_flush <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_vld   <= 1'b0;
            r_s0_addr  <= '0;
            r_s0_din   <= '0;
            r_s0_first <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_din   <= '0;
            r_s1_first <= 1'b0;
            r_rdq      <= '0;
        end else begin
            r_s0_vld   <= w_accept && valid;
            r_s0_addr  <= cnt;
            r_s0_din   <= din;
            r_s0_first <= w_first;
            r_s1_vld   <= r_s0_vld;
            r_s1_addr  <= r_s0_addr;
            r_s1_din   <= r_s0_din;
            r_s1_first <= r_s0_first;
            r_rdq      <= w_fwd ? w_sum : r_mem[w_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (r_s1_vld && !rst) begin
            r_mem[r_s1_addr] <= w_sum;
        end
    end

`ifdef PULSE_AVERAGER_SHIFT_EN
    assign rd_data = r_rdq >>> avg_shift;
`else
    assign rd_data = r_rdq;
`endif
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_pulse_averager.sv
// Directed bench for pulse_averager with a behavioural pulse generator.
// ACC_WIDTH is 16 so the wrap case can be exercised on the same instance.
module tb_pulse_averager;

    logic               clk = 1'b0;
    logic               rst;
    logic               arm;
    logic [7:0]         n_avg;
    logic               start;
    logic               valid;
    logic [7:0]         cnt;
    logic signed [13:0] din;
    logic               busy;
    logic               done;
    logic [7:0]         rd_addr;
    logic signed [15:0] rd_data;
`ifdef PULSE_AVERAGER_SHIFT_EN
    logic [4:0]         avg_shift;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    pulse_averager #(
        .DATA_WIDTH (14),
        .ADDR_WIDTH (8),
        .ACC_WIDTH  (16),
        .N_AVG_WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .n_avg    (n_avg),
        .start    (start),
        .valid    (valid),
        .cnt      (cnt),
        .din      (din),
`ifdef PULSE_AVERAGER_SHIFT_EN
        .avg_shift(avg_shift),
`endif
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag,
                   $signed(obs), $signed(exp));
        end
    endtask

    task automatic arm_go(input int n);
        arm   = 1'b1;
        n_avg = 8'(n);
        start = 1'b0;
        valid = 1'b0;
        step();
        arm = 1'b0;
    endtask

    // mode 1: din = cnt*10, mode 0: din = val
    task automatic gen(input int period, input int width, input int cycles,
                       input int mode, input int val);
        for (int c = 0; c < cycles; c++) begin
            int ci;
            ci    = c % period;
            cnt   = 8'(ci);
            start = (ci == 0);
            valid = (ci < width);
            din   = (mode == 1) ? 14'(ci * 10) : 14'(val);
            step();
        end
        start = 1'b0;
        valid = 1'b0;
        din   = '0;
    endtask

    task automatic rd_chk(input string tag, input int addr, input int exp);
        logic signed [15:0] e;
        e       = 16'(exp);
        rd_addr = 8'(addr);
        step();
        chk(tag, rd_data, e);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; n_avg = '0; start = 1'b0;
        valid = 1'b0; cnt = '0; din = '0; rd_addr = '0;
`ifdef PULSE_AVERAGER_SHIFT_EN
        avg_shift = '0;
`endif
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rd_data, 0);
        rst = 1'b0;
        step();

        // single period, busy drops 3 cycles after the 2nd start
        arm_go(1);
        chk("arm_busy", busy, 1);
        gen(10, 4, 11, 1, 0);
        chk("flush1_busy", busy, 1);
        step();
        chk("flush2_busy", busy, 1);
        step();
        chk("done_busy", busy, 0);
        chk("done_done", done, 1);
        for (int a = 0; a < 4; a++) rd_chk("single", a, a * 10);

        // coherent sum, 5th start sample discarded
        arm_go(4);
        gen(16, 8, 65, 0, -5);
        step();
        step();
        chk("sum_done", done, 1);
        for (int a = 0; a < 8; a++) rd_chk("sum", a, -20);

        // overwrite on re-arm
        arm_go(2);
        gen(8, 4, 17, 0, 100);
        step();
        step();
        rd_chk("ow_first", 0, 200);
        arm_go(1);
        gen(8, 4, 9, 0, 7);
        step();
        step();
        for (int a = 0; a < 4; a++) rd_chk("overwrite", a, 7);

        // forwarding with period 1
        arm_go(8);
        gen(1, 1, 9, 0, 3);
        step();
        step();
        rd_chk("forward", 0, 24);

        // wrap modulo 2^16
        arm_go(8);
        gen(1, 1, 9, 0, 8191);
        step();
        step();
        rd_chk("wrap", 0, -8);

        // n_avg=0 behaves as 1
        arm_go(0);
        gen(4, 2, 5, 0, 9);
        step();
        step();
        chk("navg0_done", done, 1);
        rd_chk("navg0_a0", 0, 9);
        rd_chk("navg0_a1", 1, 9);

`ifdef PULSE_AVERAGER_SHIFT_EN
        arm_go(4);
        gen(4, 2, 17, 0, 12);
        step();
        step();
        avg_shift = 5'd2;
        rd_chk("shift", 0, 12);
        avg_shift = 5'd0;
        rd_chk("noshift", 0, 48);
`endif

        // reset mid-acquisition
        arm_go(4);
        gen(8, 4, 6, 0, 1);
        chk("acq_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
